// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

  localparam int SAR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRIAL = 2'b01,
    DONE  = 2'b10
  } sar_state_e;

  // Comparator flags as seen from this block: eq=C2, gt=C1 (target>guess), lt=C0.
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } sar_flags_t;

  function automatic logic flags_onehot(input sar_flags_t f);
    return $countones(f) == 1;
  endfunction

endpackage

// File: rtl/sar_next_guess.sv
// Combinational trial step: resolves bit idx from the comparator flags and arms bit idx-1.
module sar_next_guess
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] guess,
  input  logic [IDX_W-1:0] idx,
  input  sar_flags_t       flags,
  output logic [WIDTH-1:0] decided,
  output logic [WIDTH-1:0] next_guess,
  output logic             flag_bad
);

  logic keep;

  // Priority eq > gt > lt: either of the first two keeps the bit; lt or no flag clears it.
  assign keep     = flags.eq | flags.gt;
  assign flag_bad = !flags_onehot(flags);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam logic [IDX_W-1:0] BIT_IDX = IDX_W'(i);
    assign decided[i] = (idx == BIT_IDX) ? keep : guess[i];
    if (i < WIDTH-1) begin : g_arm
      localparam logic [IDX_W-1:0] UP_IDX = IDX_W'(i + 1);
      assign next_guess[i] = (idx == UP_IDX) | decided[i];
    end else begin : g_top
      assign next_guess[i] = decided[i];
    end
  end

endmodule

// File: rtl/sar_search.sv
// SAR search controller driving comparator B and converging on the target on comparator A.
// Optional SAR_EARLY_EXIT_EN: an exact match ends the search on that trial.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             eq,
  input  logic             gt,
  input  logic             lt,
  output logic [WIDTH-1:0] guess,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             flag_err
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB     = WIDTH'(1) << (WIDTH - 1);

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  sar_state_e       state, state_nxt;
  logic [IDX_W-1:0] idx;
  sar_flags_t       flags;
  logic [WIDTH-1:0] decided, next_guess;
  logic             flag_bad, last_trial;

  assign flags = {eq, gt, lt};

  sar_next_guess #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_next (
    .guess      (guess),
    .idx        (idx),
    .flags      (flags),
    .decided    (decided),
    .next_guess (next_guess),
    .flag_bad   (flag_bad)
  );

  // On an early eq the trial bit is kept, so decided equals the guess just presented.
  assign last_trial = (idx == '0) || (EARLY_EXIT && flags.eq);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = TRIAL;
      TRIAL:   if (last_trial) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == TRIAL);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      guess    <= '0;
      result   <= '0;
      idx      <= IDX_TOP;
      found    <= 1'b0;
      flag_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          guess    <= MSB;
          idx      <= IDX_TOP;
          found    <= 1'b0;
          flag_err <= 1'b0;
        end
        TRIAL: begin
          if (flags.eq) found    <= 1'b1;
          if (flag_bad) flag_err <= 1'b1;
          if (last_trial) begin
            result <= decided;
            guess  <= decided;
          end else begin
            guess <= next_guess;
            idx   <= idx - IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search with a behavioural comparator and closed-form search model.
module tb_sar_search;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, start, eq, gt, lt;
  logic [W-1:0] guess, result;
  logic         busy, done, found, flag_err;

  logic [W-1:0] target;
  logic         force_on;
  logic [2:0]   force_val;

  typedef struct {
    logic [W-1:0] tgt;
    logic [W-1:0] res;
    logic         found;
    logic         err;
    int           trials;
    bit           chk_seq;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] seq[$];
  int           busy_cnt;
  logic [W-1:0] last_result;
  int           vectors, miscompares;

  sar_search #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .eq(eq), .gt(gt), .lt(lt),
    .guess(guess), .result(result), .busy(busy), .done(done),
    .found(found), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  // Comparator model, with an override used to inject illegal flag patterns.
  always_comb begin
    if (force_on) {eq, gt, lt} = force_val;
    else begin
      eq = (target == guess);
      gt = (target > guess);
      lt = (target < guess);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // A binary search on t lands exactly on t; it hits eq on the trial for t's lowest set bit.
  function automatic exp_t ref_model(input logic [W-1:0] t);
    exp_t e;
    int   lsb;
    e.tgt = t; e.res = t; e.found = (t != 0); e.err = 1'b0;
    e.trials = W; e.chk_seq = 1'b1;
`ifdef SAR_EARLY_EXIT_EN
    lsb = -1;
    for (int b = W-1; b >= 0; b--) if (t[b]) lsb = b;
    if (lsb >= 0) e.trials = W - lsb;
`else
    lsb = 0;
`endif
    return e;
  endfunction

  // Guess presented on trial i (1-based): t's bits above position b, then a 1 at b.
  function automatic logic [W-1:0] exp_guess(input logic [W-1:0] t, input int i);
    int b, g;
    b = W - i;
    g = (int'(t) & ~((1 << (b + 1)) - 1)) | (1 << b);
    return W'(g);
  endfunction

  function automatic exp_t fault_exp(input logic [W-1:0] t, input logic [W-1:0] r,
                                     input logic f, input int tr);
    exp_t e;
    e.tgt = t; e.res = r; e.found = f; e.err = 1'b1; e.trials = tr; e.chk_seq = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (busy) begin
        busy_cnt++;
        seq.push_back(guess);
        check("result_hold", result, last_result);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_done: got result %0d expected no done", result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("result(t=%0d)", e.tgt), result, e.res);
          check($sformatf("found(t=%0d)", e.tgt), found, e.found);
          check($sformatf("flag_err(t=%0d)", e.tgt), flag_err, e.err);
          check($sformatf("trials(t=%0d)", e.tgt), busy_cnt, e.trials);
          if (e.chk_seq) begin
            check($sformatf("seq_len(t=%0d)", e.tgt), seq.size(), e.trials);
            for (int i = 0; i < seq.size() && i < e.trials; i++)
              check($sformatf("guess%0d(t=%0d)", i+1, e.tgt), seq[i], exp_guess(e.tgt, i+1));
          end
        end
        last_result = result;
        busy_cnt = 0;
        seq.delete();
      end
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
  endtask

  // Called at a negedge; returns one idle negedge after done.
  task automatic do_search(input logic [W-1:0] t, input int fz_trial, input logic [2:0] fz,
                           input exp_t e, input bit spam);
    int n;
    target = t; force_val = fz; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = spam;
    n = 1;
    while (!done && n < 20) begin
      force_on = (n == fz_trial);
      @(negedge clk);
      n++;
    end
    start = 1'b0; force_on = 1'b0;
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: got no done for t=%0d expected done", t);
    end else check($sformatf("latency(t=%0d)", t), n - 1, e.trials);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_not_busy", busy, 0);
  endtask

  initial begin
    int   n;
    logic [W-1:0] t;
    vectors = 0; miscompares = 0; busy_cnt = 0; last_result = '0;
    reset = 1'b1; start = 1'b0; target = '0; force_on = 1'b0; force_val = 3'b000;
    repeat (2) @(negedge clk);
    check("rst_guess", guess, 0);   check("rst_result", result, 0);
    check("rst_busy", busy, 0);     check("rst_done", done, 0);
    check("rst_found", found, 0);   check("rst_flag_err", flag_err, 0);
    reset = 1'b0;
    @(negedge clk);

    do_search(4'd5,  0, 3'b000, ref_model(4'd5), 1'b0);
    do_search(4'd0,  0, 3'b000, ref_model(4'd0), 1'b0);
    do_search(4'd15, 0, 3'b000, ref_model(4'd15), 1'b0);

    // eq and gt together on trial 2 of target 9: bit kept, match recorded, error flagged.
`ifdef SAR_EARLY_EXIT_EN
    do_search(4'd9, 2, 3'b110, fault_exp(4'd9, 4'd12, 1'b1, 2), 1'b0);
`else
    do_search(4'd9, 2, 3'b110, fault_exp(4'd9, 4'd12, 1'b1, 4), 1'b0);
`endif
    repeat (2) @(negedge clk);
    check("err_sticky", flag_err, 1);
    do_search(4'd6, 0, 3'b000, ref_model(4'd6), 1'b0);
    // No flags on trial 1 of target 15 behaves as lt.
    do_search(4'd15, 1, 3'b000, fault_exp(4'd15, 4'd7, 1'b0, 4), 1'b0);

    // Asynchronous reset in the middle of trial 3.
    target = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_before_rst", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_guess", guess, 0);   check("arst_result", result, 0);
    check("arst_busy", busy, 0);     check("arst_done", done, 0);
    check("arst_found", found, 0);   check("arst_flag_err", flag_err, 0);
    exp_q.delete(); seq.delete(); busy_cnt = 0; last_result = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_search(4'd12, 0, 3'b000, ref_model(4'd12), 1'b0);

    // start asserted on every cycle while busy.
    do_search(4'd10, 0, 3'b000, ref_model(4'd10), 1'b1);

    // start held high across two searches: one IDLE cycle between them.
    target = 4'd3; start = 1'b1;
    exp_q.push_back(ref_model(4'd3));
    @(negedge clk);
    wait_done(n);
    target = 4'd13;
    exp_q.push_back(ref_model(4'd13));
    @(negedge clk);
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_done", done, 0);
    @(negedge clk);
    check("b2b_restart", busy, 1);
    start = 1'b0;
    wait_done(n);
    @(negedge clk);

    repeat (40) begin
      t = W'($urandom_range(0, (1 << W) - 1));
      do_search(t, 0, 3'b000, ref_model(t), $urandom_range(0, 1) == 1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
